// File: rtl/mips_stage2_decode.sv
// MIPS instruction-decode stage: IF/ID register, register file with write-first
// bypass, immediate extension, control decode, load-use stall and ID/EX register.
module mips_stage2_decode #(
    parameter int REG_COUNT = 32,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    input  logic            if_valid,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_out,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [5:0]      id_opcode,
    output logic [5:0]      id_funct,
    output logic [4:0]      id_rs,
    output logic [4:0]      id_rt,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_rs_data,
    output logic [XLEN-1:0] id_rt_data,
    output logic [XLEN-1:0] id_imm,
    output logic            id_mem_read,
    output logic            id_reg_write
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_inst;

    logic [XLEN-1:0] regs [REG_COUNT];

    logic [5:0]      dec_opcode;
    logic [5:0]      dec_funct;
    logic [4:0]      dec_rs;
    logic [4:0]      dec_rt;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_rs_data;
    logic [XLEN-1:0] dec_rt_data;
    logic            dec_mem_read;
    logic            dec_reg_write;
    logic            dec_uses_rt;
    logic            dec_zero_ext;
    logic            bubble;

    assign dec_opcode = ifid_inst[31:26];
    assign dec_rs     = ifid_inst[25:21];
    assign dec_rt     = ifid_inst[20:16];
    assign dec_funct  = ifid_inst[5:0];
    assign dec_rd     = (dec_opcode == OP_RTYPE) ? ifid_inst[15:11] : ifid_inst[20:16];

    assign dec_zero_ext = (dec_opcode == OP_ANDI) || (dec_opcode == OP_ORI) ||
                          (dec_opcode == OP_XORI);
    assign dec_imm = dec_zero_ext ? {{(XLEN-16){1'b0}}, ifid_inst[15:0]}
                                  : {{(XLEN-16){ifid_inst[15]}}, ifid_inst[15:0]};

    assign dec_mem_read  = (dec_opcode == OP_LW);
    assign dec_reg_write = (dec_opcode == OP_RTYPE) || (dec_opcode == OP_ADDI) ||
                           (dec_opcode == OP_LW);
    assign dec_uses_rt   = (dec_opcode == OP_RTYPE) || (dec_opcode == OP_SW) ||
                           (dec_opcode == OP_BEQ)   || (dec_opcode == OP_BNE);

    // Write-first: a write-back landing this edge is visible to the reader now.
    always_comb begin
        dec_rs_data = regs[dec_rs];
        if (dec_rs == 5'd0)
            dec_rs_data = '0;
        else if (wb_we && (wb_addr == dec_rs))
            dec_rs_data = wb_data;
    end

    always_comb begin
        dec_rt_data = regs[dec_rt];
        if (dec_rt == 5'd0)
            dec_rt_data = '0;
        else if (wb_we && (wb_addr == dec_rt))
            dec_rt_data = wb_data;
    end

    // The load in ID/EX has not produced its data yet; hold the consumer one cycle.
    assign stall_out = ifid_valid && id_valid && id_mem_read && (id_rd != 5'd0) &&
                       ((id_rd == dec_rs) || ((id_rd == dec_rt) && dec_uses_rt));

    assign bubble = flush || stall_out || !ifid_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else if (wb_we && (wb_addr != 5'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_inst  <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (!stall_out) begin
            ifid_valid <= if_valid;
            ifid_pc    <= if_pc;
            ifid_inst  <= if_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_opcode    <= '0;
            id_funct     <= '0;
            id_rs        <= '0;
            id_rt        <= '0;
            id_rd        <= '0;
            id_rs_data   <= '0;
            id_rt_data   <= '0;
            id_imm       <= '0;
            id_mem_read  <= 1'b0;
            id_reg_write <= 1'b0;
        end else if (bubble) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_opcode    <= '0;
            id_funct     <= '0;
            id_rs        <= '0;
            id_rt        <= '0;
            id_rd        <= '0;
            id_rs_data   <= '0;
            id_rt_data   <= '0;
            id_imm       <= '0;
            id_mem_read  <= 1'b0;
            id_reg_write <= 1'b0;
        end else begin
            id_valid     <= 1'b1;
            id_pc        <= ifid_pc;
            id_opcode    <= dec_opcode;
            id_funct     <= dec_funct;
            id_rs        <= dec_rs;
            id_rt        <= dec_rt;
            id_rd        <= dec_rd;
            id_rs_data   <= dec_rs_data;
            id_rt_data   <= dec_rt_data;
            id_imm       <= dec_imm;
            id_mem_read  <= dec_mem_read;
            id_reg_write <= dec_reg_write;
        end
    end

endmodule

// File: tb/tb_mips_stage2_decode.sv
// Bench for mips_stage2_decode: instruction-level reference model compared every
// cycle, plus hand-computed literal checks for each directed scenario.
module tb_mips_stage2_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        stall_out, id_valid, id_mem_read, id_reg_write;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;

    mips_stage2_decode dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_out(stall_out), .id_valid(id_valid), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the instruction in each slot must look like.
    typedef struct packed {
        bit        valid;
        bit [31:0] pc;
        bit [5:0]  op;
        bit [5:0]  funct;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  rd;
        bit [31:0] rsd;
        bit [31:0] rtd;
        bit [31:0] imm;
        bit        mr;
        bit        rw;
    } idex_t;

    bit [31:0] m_regs [32];
    bit        m_fv;
    bit [31:0] m_fpc;
    bit [31:0] m_finst;
    idex_t     m_id;

    function automatic bit [31:0] m_read(input bit [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic idex_t m_decode(input bit [31:0] pc, input bit [31:0] inst);
        idex_t d;
        bit [5:0] op;
        op      = inst[31:26];
        d.valid = 1'b1;
        d.pc    = pc;
        d.op    = op;
        d.funct = inst[5:0];
        d.rs    = inst[25:21];
        d.rt    = inst[20:16];
        d.rd    = (op == 6'h00) ? inst[15:11] : inst[20:16];
        d.rsd   = m_read(d.rs);
        d.rtd   = m_read(d.rt);
        d.imm   = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, inst[15:0]}
                                                   : {{16{inst[15]}}, inst[15:0]};
        d.mr    = (op == 6'h23);
        d.rw    = (op inside {6'h00, 6'h08, 6'h23});
        return d;
    endfunction

    function automatic bit m_stall();
        bit [4:0] rs, rt;
        bit uses_rt;
        rs = m_finst[25:21];
        rt = m_finst[20:16];
        uses_rt = (m_finst[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05});
        return m_fv && m_id.valid && m_id.mr && (m_id.rd != 0) &&
               ((m_id.rd == rs) || (m_id.rd == rt && uses_rt));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_fv = 1'b0; m_fpc = 32'h0; m_finst = 32'h0; m_id = '0;
    endtask

    always @(negedge rst) m_reset();

    always @(posedge clk) begin
        bit s;
        idex_t n;
        if (!rst) begin
            m_reset();
        end else begin
            s = m_stall();
            n = (flush || s || !m_fv) ? idex_t'(0) : m_decode(m_fpc, m_finst);
            if (flush) m_fv = 1'b0;
            else if (!s) begin m_fv = if_valid; m_fpc = if_pc; m_finst = if_inst; end
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
            m_id = n;
        end
    end

    always @(negedge clk) begin
        chk("stall_out",    {31'h0, stall_out},    {31'h0, m_stall()});
        chk("id_valid",     {31'h0, id_valid},     {31'h0, m_id.valid});
        chk("id_pc",        id_pc,                 m_id.pc);
        chk("id_opcode",    {26'h0, id_opcode},    {26'h0, m_id.op});
        chk("id_funct",     {26'h0, id_funct},     {26'h0, m_id.funct});
        chk("id_rs",        {27'h0, id_rs},        {27'h0, m_id.rs});
        chk("id_rt",        {27'h0, id_rt},        {27'h0, m_id.rt});
        chk("id_rd",        {27'h0, id_rd},        {27'h0, m_id.rd});
        chk("id_rs_data",   id_rs_data,            m_id.rsd);
        chk("id_rt_data",   id_rt_data,            m_id.rtd);
        chk("id_imm",       id_imm,                m_id.imm);
        chk("id_mem_read",  {31'h0, id_mem_read},  {31'h0, m_id.mr});
        chk("id_reg_write", {31'h0, id_reg_write}, {31'h0, m_id.rw});
    end

    bit [31:0] pc = 32'h0000_0400;
    bit [31:0] pc_add;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input bit [31:0] inst);
        if_pc = pc; if_inst = inst; if_valid = 1'b1; pc += 4;
    endtask

    task automatic idle();
        if_valid = 1'b0;
    endtask

    task automatic wbset(input bit we, input bit [4:0] a, input bit [31:0] d);
        wb_we = we; wb_addr = a; wb_data = d;
    endtask

    initial begin
        repeat (2) cyc();
        chk("reset stall_out", {31'h0, stall_out}, 32'h0);
        chk("reset id_valid", {31'h0, id_valid}, 32'h0);
        rst = 1'b1;
        cyc();

        // Register load, read and immediate
        wbset(1, 5, 32'h0000_1234); idle(); cyc(); wbset(0, 0, 0);
        put(32'h20A6_0004); cyc(); idle(); cyc();
        chk("addi id_valid", {31'h0, id_valid}, 32'h1);
        chk("addi rs_data", id_rs_data, 32'h0000_1234);
        chk("addi imm", id_imm, 32'h0000_0004);
        chk("addi rd", {27'h0, id_rd}, 32'd6);
        chk("addi reg_write", {31'h0, id_reg_write}, 32'h1);

        // Write-first bypass
        put(32'h00E0_4020); cyc();
        idle(); wbset(1, 7, 32'h0000_CAFE); cyc(); wbset(0, 0, 0);
        chk("bypass rs_data", id_rs_data, 32'h0000_CAFE);
        chk("bypass rd", {27'h0, id_rd}, 32'd8);

        // $0 stays zero even when written or bypassed
        wbset(1, 0, 32'h0000_FFFF); cyc(); wbset(0, 0, 0);
        put(32'h2009_0001); cyc();
        idle(); wbset(1, 0, 32'h0000_FFFF); cyc(); wbset(0, 0, 0);
        chk("r0 rs_data", id_rs_data, 32'h0);

        // Load-use: one stall, one bubble, then the consumer
        put(32'h8C02_0000); cyc();
        pc_add = pc; put(32'h0041_1820); cyc();
        chk("loaduse stall", {31'h0, stall_out}, 32'h1);
        chk("loaduse lw mem_read", {31'h0, id_mem_read}, 32'h1);
        cyc();
        chk("loaduse bubble", {31'h0, id_valid}, 32'h0);
        chk("loaduse stall gone", {31'h0, stall_out}, 32'h0);
        idle(); cyc();
        chk("loaduse add valid", {31'h0, id_valid}, 32'h1);
        chk("loaduse add pc", id_pc, pc_add);
        chk("loaduse add rd", {27'h0, id_rd}, 32'd3);
        cyc();

        // lw then lw using rs -> stall
        put(32'h8C02_0000); cyc(); put(32'h8C44_0000); cyc();
        chk("lw-lw stall", {31'h0, stall_out}, 32'h1);
        cyc(); idle(); repeat (2) cyc();
        // lw $2 then addi writing $2 (rt not a source) -> no stall
        put(32'h8C02_0000); cyc(); put(32'h2062_0001); cyc();
        chk("lw-addi no stall", {31'h0, stall_out}, 32'h0);
        idle(); repeat (2) cyc();
        // lw to $0 never stalls
        put(32'h8C40_0000); cyc(); put(32'h0000_1820); cyc();
        chk("lw r0 no stall", {31'h0, stall_out}, 32'h0);
        idle(); repeat (2) cyc();

        // Flush during the stall cycle wins
        put(32'h8C02_0000); cyc(); put(32'h0041_1820); cyc();
        chk("flush pre stall", {31'h0, stall_out}, 32'h1);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("flush id_valid", {31'h0, id_valid}, 32'h0);
        chk("flush stall", {31'h0, stall_out}, 32'h0);
        idle(); cyc();
        chk("flush ifid cleared", {31'h0, id_valid}, 32'h0);
        put(32'h20A6_0004); cyc(); idle(); cyc();
        chk("post flush valid", {31'h0, id_valid}, 32'h1);
        chk("post flush rs_data", id_rs_data, 32'h0000_1234);

        // Immediate extension
        put(32'h2001_8000); cyc(); put(32'h3401_8000); cyc();
        chk("addi sign ext", id_imm, 32'hFFFF_8000);
        put(32'h3001_8000); cyc();
        chk("ori zero ext", id_imm, 32'h0000_8000);
        idle(); cyc();
        chk("andi zero ext", id_imm, 32'h0000_8000);
        cyc();

        // Asynchronous reset while full and stalled
        put(32'h8C02_0000); cyc(); put(32'h0041_1820); cyc();
        chk("pre reset stall", {31'h0, stall_out}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("async rst stall", {31'h0, stall_out}, 32'h0);
        chk("async rst id_valid", {31'h0, id_valid}, 32'h0);
        chk("async rst id_pc", id_pc, 32'h0);
        chk("async rst mem_read", {31'h0, id_mem_read}, 32'h0);
        chk("async rst rs_data", id_rs_data, 32'h0);
        idle();
        cyc();
        rst = 1'b1;
        cyc();
        for (int r = 1; r < 32; r++) begin
            bit [4:0] rr;
            rr = r[4:0];
            put({6'h08, rr, 5'd0, 16'h0}); cyc(); idle(); cyc();
            chk($sformatf("reg%0d after reset", r), id_rs_data, 32'h0);
        end
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
